// File: rtl/uart_tx_fifo_if.sv
// Byte-enqueue handshake between the execution stage (master) and the
// buffered UART transmitter (slave).
interface uart_tx_fifo_if;
  logic [7:0] wdata;
  logic       wvalid;
  logic       wready;

  modport master (output wdata, output wvalid, input wready);
  modport slave  (input wdata, input wvalid, output wready);
endinterface

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: byte FIFO drained by an 8N1 serializer (LSB first).
// Define UART_TX_PARITY_EN to insert an even-parity bit (8E1 framing).
module uart_tx_fifo #(
  parameter int CLK_PER_BIT = 868,
  parameter int DEPTH_LOG2  = 4
) (
  input  logic                clk,
  input  logic                rstn,
  uart_tx_fifo_if.slave       wr_if,
  output logic                busy_o,
  output logic [DEPTH_LOG2:0] count_o,
  output logic                txd_o
);
  localparam int                  DEPTH     = 2 ** DEPTH_LOG2;
  localparam int                  BAUD_W    = $clog2(CLK_PER_BIT);
  localparam logic [DEPTH_LOG2:0] FULL      = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [BAUD_W-1:0]   BAUD_LAST = BAUD_W'(CLK_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    PARITY = 3'd4,
`endif
    STOP   = 3'd3
  } state_e;

  state_e                state_q, state_d;
  logic [BAUD_W-1:0]     baud_q, baud_d;
  logic [2:0]            bit_q, bit_d;
  logic [7:0]            shift_q, shift_d;
  logic                  txd_q, txd_d;
  logic                  line_active_q;
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic [7:0]            mem_q [DEPTH];
  logic                  push, pop, baud_end;
`ifdef UART_TX_PARITY_EN
  logic                  parity_q, parity_d;
`endif

  assign wr_if.wready = (count_q != FULL);
  assign push         = wr_if.wvalid && wr_if.wready;
  assign baud_end     = (baud_q == BAUD_LAST);

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr_if.wdata;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + (DEPTH_LOG2 + 1)'(1);
      2'b01:   count_d = count_q - (DEPTH_LOG2 + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Serializer next-state; pop only ever happens with count_q != 0.
  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    pop      = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d = parity_q;
`endif
    case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          pop     = 1'b1;
          state_d = START;
          baud_d  = '0;
        end
      end
      START: begin
        if (baud_end) begin
          state_d = DATA;
          baud_d  = '0;
          bit_d   = '0;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      DATA: begin
        if (baud_end) begin
          baud_d  = '0;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (baud_end) begin
          state_d = STOP;
          baud_d  = '0;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
`endif
      STOP: begin
        if (baud_end) begin
          baud_d = '0;
          // Chain straight into the next start bit so queued bytes leave gap-free.
          if (count_q != '0) begin
            pop     = 1'b1;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        baud_d  = '0;
      end
    endcase
    if (pop) begin
      shift_d  = mem_q[rd_ptr_q];
`ifdef UART_TX_PARITY_EN
      parity_d = ^mem_q[rd_ptr_q];
`endif
    end
  end

  always_comb begin
    txd_d = 1'b1;
    case (state_q)
      START:   txd_d = 1'b0;
      DATA:    txd_d = shift_q[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  txd_d = parity_q;
`endif
      default: txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q       <= IDLE;
      baud_q        <= '0;
      bit_q         <= '0;
      shift_q       <= '0;
      txd_q         <= 1'b1;
      line_active_q <= 1'b0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
`ifdef UART_TX_PARITY_EN
      parity_q      <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      baud_q        <= baud_d;
      bit_q         <= bit_d;
      shift_q       <= shift_d;
      txd_q         <= txd_d;
      line_active_q <= (state_q != IDLE);
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
`ifdef UART_TX_PARITY_EN
      parity_q      <= parity_d;
`endif
    end
  end

  // txd lags the FSM by one cycle; line_active_q holds busy through the last stop bit on the wire.
  assign busy_o  = (state_q != IDLE) || (count_q != '0) || line_active_q;
  assign count_o = count_q;
  assign txd_o   = txd_q;
endmodule
